// File: rtl/elastic_buffer_pkg.sv
// elastic_pkg: shared types and helpers for the elastic FIFO slice.
package elastic_pkg;

  // Occupancy classes derived from the stored-entry count.
  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } elastic_state_t;

  // Pointer width: index bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/elastic_buffer_ptr.sv
// elastic_ptr: wrap-bit pointer counter, counts modulo 2*DEPTH.
// DEPTH is a power of two, so a plain binary increment of the
// index-plus-wrap word toggles the wrap bit when the index wraps.
module elastic_ptr
  import elastic_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         inc,
  output logic [ptr_width(DEPTH)-1:0]  o_ptr
);

  logic [ptr_width(DEPTH)-1:0] r_ptr;

  // Pointer register: async reset, synchronous clear dominates increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (clear) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/elastic_buffer.sv
// elastic_buffer: parametrised ready/valid elastic FIFO with level,
// almost-full and synchronous flush.
// Optional first-word fall-through bypass: define ELASTIC_BYPASS_EN.
module elastic_buffer
  import elastic_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ALMOST_FULL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       input_valid,
  output logic                       input_ready,
  input  logic [WIDTH-1:0]           input_data,
  output logic                       output_valid,
  input  logic                       output_ready,
  output logic [WIDTH-1:0]           output_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned IW = PW - 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] AF_LEVEL = LW'(ALMOST_FULL);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [PW-1:0]    w_wr_ptr;
  logic [PW-1:0]    w_rd_ptr;
  logic [IW-1:0]    w_wr_idx;
  logic [IW-1:0]    w_rd_idx;
  logic [PW-1:0]    w_diff;
  logic             w_empty;
  logic             w_full;
  elastic_state_t   w_state;
  logic             w_insert;
  logic             w_remove;
  logic             w_passthru;
  logic             w_wr_inc;
  logic             w_rd_inc;

  assign w_wr_idx = w_wr_ptr[IW-1:0];
  assign w_rd_idx = w_rd_ptr[IW-1:0];
  assign w_diff   = w_wr_ptr - w_rd_ptr;
  assign w_empty  = (w_wr_ptr == w_rd_ptr);
  assign w_full   = (w_wr_idx == w_rd_idx) && (w_wr_ptr[PW-1] != w_rd_ptr[PW-1]);

  // Occupancy class from registered pointers only.
  always_comb begin
    w_state = PARTIAL;
    if (w_empty) begin
      w_state = EMPTY;
    end else if (w_full) begin
      w_state = FULL;
    end
  end

  assign level       = LW'(w_diff);
  assign almost_full = (level >= AF_LEVEL);

  // Flush is the only combinational term on input_ready.
  assign input_ready = (w_state != FULL) && !flush;

`ifdef ELASTIC_BYPASS_EN
  // When empty the producer word is presented directly; if taken in the
  // same cycle it never touches storage or the pointers.
  assign output_valid = !flush && ((w_state != EMPTY) || input_valid);
  assign output_data  = (w_state == EMPTY) ? input_data : r_mem[w_rd_idx];
  assign w_passthru   = (w_state == EMPTY) && w_insert && w_remove;
`else
  assign output_valid = !flush && (w_state != EMPTY);
  assign output_data  = r_mem[w_rd_idx];
  assign w_passthru   = 1'b0;
`endif

  assign w_insert = input_valid && input_ready;
  assign w_remove = output_valid && output_ready;
  assign w_wr_inc = w_insert && !w_passthru;
  assign w_rd_inc = w_remove && !w_passthru;

  // Storage write; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_inc) begin
      r_mem[w_wr_idx] <= input_data;
    end
  end

  elastic_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .inc     (w_wr_inc),
    .o_ptr   (w_wr_ptr)
  );

  elastic_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .inc     (w_rd_inc),
    .o_ptr   (w_rd_ptr)
  );

endmodule

// File: tb/tb_elastic_buffer.sv
// Scoreboard bench for elastic_buffer (DEPTH=4, WIDTH=8, ALMOST_FULL=3).
// Inputs change at negedge+1, the monitor samples at negedge+4, edges at posedge.
module tb_elastic_buffer;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned AF = 3;
`ifdef ELASTIC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         input_valid = 1'b0;
  logic         input_ready;
  logic [W-1:0] input_data = '0;
  logic         output_valid;
  logic         output_ready = 1'b0;
  logic [W-1:0] output_data;
  logic [2:0]   level;
  logic         almost_full;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model_q[$];

  elastic_buffer #(.WIDTH(W), .DEPTH(D), .ALMOST_FULL(AF)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .level        (level),
    .almost_full  (almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    @(negedge clk);
    #1;
    input_valid  = v;
    input_data   = d;
    output_ready = r;
    flush        = f;
  endtask

  // Monitor: reference FIFO as a queue; accepted words are pushed, taken words popped.
  initial begin
    int       sz;
    bit       exp_ir, exp_ov, ins, rem;
    logic [W-1:0] head;
    forever begin
      @(negedge clk);
      #4;
      if (!reset_n) begin
        check("rst_level", level, 0);
        check("rst_ovalid", output_valid, 0);
        check("rst_iready", input_ready, !flush);
        check("rst_afull", almost_full, 0);
      end else begin
        sz     = model_q.size();
        exp_ir = !flush && (sz < D);
        exp_ov = !flush && ((sz > 0) || (BYP && input_valid));
        check("level", level, sz);
        check("input_ready", input_ready, exp_ir);
        check("output_valid", output_valid, exp_ov);
        check("almost_full", almost_full, (sz >= AF));
        ins = input_valid && exp_ir;
        rem = exp_ov && output_ready;
        if (exp_ov) begin
          head = (sz > 0) ? model_q[0] : input_data;
          check("output_data", output_data, head);
        end
        if (rem && sz > 0) void'(model_q.pop_front());
        if (ins && !(rem && sz == 0)) model_q.push_back(input_data);
        if (flush) model_q.delete();
      end
    end
  end

  // Stimulus
  initial begin
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;

    // Fill to full with consumer stalled, try one extra push, then drain.
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 0, 0);
    cyc(1, 8'h44, 0, 0);
    cyc(1, 8'h55, 0, 0);
    @(negedge clk);
    #2;
    check("full_level", level, 4);
    check("full_iready", input_ready, 0);
    check("full_afull", almost_full, 1);
    input_valid = 1'b0;
    repeat (5) cyc(0, 8'h00, 1, 0);

    // Continuous streaming.
    for (int i = 0; i < 16; i++) cyc(1, W'(i), 1, 0);
    repeat (2) cyc(0, 8'h00, 1, 0);

    // Stall with head 0xA5.
    cyc(1, 8'hA5, 0, 0);
    repeat (5) begin
      cyc(0, 8'h00, 0, 0);
      #2;
      check("hold_valid", output_valid, 1);
      check("hold_data", output_data, 8'hA5);
    end
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);

    // Flush at level 3 with both handshakes requested.
    repeat (3) cyc(1, 8'h5C, 0, 0);
    cyc(1, 8'h77, 1, 1);
    #2;
    check("flush_iready", input_ready, 0);
    check("flush_ovalid", output_valid, 0);
    cyc(0, 8'h00, 0, 0);
    #2;
    check("post_flush_level", level, 0);
    check("post_flush_ovalid", output_valid, 0);

    // Asynchronous reset mid-cycle at level 2.
    cyc(1, 8'h81, 0, 0);
    cyc(1, 8'h82, 0, 0);
    @(negedge clk);
    #1;
    input_valid = 1'b0;
    check("pre_rst_level", level, 2);
    #1;
    reset_n = 1'b0;
    model_q.delete();
    #1;
    check("async_rst_ovalid", output_valid, 0);
    check("async_rst_level", level, 0);
    check("async_rst_iready", input_ready, 1);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // Randomised push/pop with gaps; pointers wrap several times.
    for (int i = 0; i < 60; i++)
      cyc(bit'($urandom_range(0, 1)), W'($urandom), bit'($urandom_range(0, 1)), 0);
    repeat (6) cyc(0, 8'h00, 1, 0);
    @(negedge clk);
    #2;
    check("final_level", level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
